// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the three-master SDRAM arbiter.
// Port indices double as grant codes; GRANT_NONE marks an unowned RAM port.
package ram_arbiter_pkg;

    localparam int NUM_PORTS = 3;

    localparam logic [1:0] PORT_VIDEO  = 2'd0;
    localparam logic [1:0] PORT_IFETCH = 2'd1;
    localparam logic [1:0] PORT_DATA   = 2'd2;
    localparam logic [1:0] GRANT_NONE  = 2'd3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Debug view of the arbiter internals, for checkers and bring-up.
    typedef struct packed {
        arb_state_e state;
        logic [7:0] wd_count;
        logic [1:0] rr_last;
    } arb_dbg_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] idx);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (idx)
            PORT_VIDEO:  oh = 3'b001;
            PORT_IFETCH: oh = 3'b010;
            PORT_DATA:   oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU/video fabric, the arbiter and the SDRAM controller.
// Handshake: a master raises m_stb (with we/addr/din stable) and holds it until it
// sees a one-cycle m_ack or m_err; only the granted master's bit ever pulses.
// ram_stb is registered and held until a one-cycle ram_ack (or watchdog release).
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int AW = 25,
    parameter int DW = 32
);
    logic [NUM_PORTS-1:0]    m_stb;
    logic [NUM_PORTS-1:0]    m_we;
    logic [NUM_PORTS*AW-1:0] m_addr;
    logic [NUM_PORTS*DW-1:0] m_din;
    logic [DW-1:0]           m_dout;
    logic [NUM_PORTS-1:0]    m_ack;
    logic [NUM_PORTS-1:0]    m_err;

    logic                    ram_stb;
    logic                    ram_we;
    logic [AW-1:0]           ram_addr;
    logic [DW-1:0]           ram_din;
    logic [DW-1:0]           ram_dout;
    logic                    ram_ack;

    logic [1:0]              grant;

    // Arbiter side.
    modport slave (
        input  m_stb, m_we, m_addr, m_din, ram_dout, ram_ack,
        output m_dout, m_ack, m_err, ram_stb, ram_we, ram_addr, ram_din, grant
    );

    // Fabric plus RAM side.
    modport master (
        output m_stb, m_we, m_addr, m_din, ram_dout, ram_ack,
        input  m_dout, m_ack, m_err, ram_stb, ram_we, ram_addr, ram_din, grant
    );

endinterface

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select: video has fixed priority, the two CPU ports
// share round-robin on rr_last_i (the CPU port served most recently).
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] m_stb_i,
    input  logic [1:0]           rr_last_i,
    output logic [1:0]           idx_o,
    output logic                 valid_o
);

    always_comb begin
        idx_o   = GRANT_NONE;
        valid_o = |m_stb_i;
        if (m_stb_i[PORT_VIDEO]) begin
            idx_o = PORT_VIDEO;
        end else if (m_stb_i[PORT_IFETCH] && m_stb_i[PORT_DATA]) begin
            idx_o = (rr_last_i == PORT_IFETCH) ? PORT_DATA : PORT_IFETCH;
        end else if (m_stb_i[PORT_IFETCH]) begin
            idx_o = PORT_IFETCH;
        end else if (m_stb_i[PORT_DATA]) begin
            idx_o = PORT_DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SDRAM port among video, CPU fetch and CPU data masters: one grant
// per transaction, registered RAM request, ack/err steering and a stuck-grant watchdog.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW      = 25,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
)(
    input  logic           clk,
    input  logic           rst_n,
    ram_arbiter_if.slave   bus,
    output arb_dbg_t       dbg_o
);

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    arb_state_e     state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     rr_last_q, rr_last_d;
    logic           ram_stb_q, ram_stb_d;
    logic           ram_we_q, ram_we_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [DW-1:0]  ram_din_q, ram_din_d;
    logic [7:0]     wd_q, wd_d;

    logic [1:0]     pick_idx;
    logic           pick_valid;
    logic           win_we;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_din;
    logic           ack_seen;
    logic           wd_expire;

    ram_arbiter_pick u_pick (
        .m_stb_i   (bus.m_stb),
        .rr_last_i (rr_last_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    always_comb begin
        win_we   = bus.m_we[0];
        win_addr = bus.m_addr[0 +: AW];
        win_din  = bus.m_din[0 +: DW];
        case (pick_idx)
            PORT_IFETCH: begin
                win_we   = bus.m_we[1];
                win_addr = bus.m_addr[AW +: AW];
                win_din  = bus.m_din[DW +: DW];
            end
            PORT_DATA: begin
                win_we   = bus.m_we[2];
                win_addr = bus.m_addr[2*AW +: AW];
                win_din  = bus.m_din[2*DW +: DW];
            end
            default: ;
        endcase
    end

    // A late ram_ack while idle (after a watchdog release) must not reach anyone.
    assign ack_seen  = (state_q == ARB_BUSY) && bus.ram_ack;
    assign wd_expire = (state_q == ARB_BUSY) && !bus.ram_ack && (wd_q == WD_LIMIT);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        ram_stb_d  = ram_stb_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        wd_d       = wd_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_BUSY;
                    grant_d    = pick_idx;
                    ram_stb_d  = 1'b1;
                    ram_we_d   = win_we;
                    ram_addr_d = win_addr;
                    ram_din_d  = win_din;
                    wd_d       = 8'd1;
                    if (pick_idx != PORT_VIDEO) begin
                        rr_last_d = pick_idx;
                    end
                end
            end
            ARB_BUSY: begin
                if (ack_seen || wd_expire) begin
                    state_d   = ARB_IDLE;
                    grant_d   = GRANT_NONE;
                    ram_stb_d = 1'b0;
                    wd_d      = '0;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= GRANT_NONE;
            rr_last_q  <= PORT_DATA;
            ram_stb_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            ram_stb_q  <= ram_stb_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.m_dout   = bus.ram_dout;
    assign bus.m_ack    = ack_seen  ? port_onehot(grant_q) : '0;
    assign bus.m_err    = wd_expire ? port_onehot(grant_q) : '0;
    assign bus.ram_stb  = ram_stb_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.grant    = grant_q;

    always_comb begin
        dbg_o          = '0;
        dbg_o.state    = state_q;
        dbg_o.wd_count = wd_q;
        dbg_o.rr_last  = rr_last_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run,
// with expected grants derived from the priority/round-robin rules.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int TO = 8;

    logic     clk = 1'b0;
    logic     rst_n;
    arb_dbg_t dbg;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dbg_o (dbg)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    bit [2:0]      req;
    bit [2:0]      we_a;
    logic [AW-1:0] addr_a [3];
    logic [DW-1:0] din_a  [3];
    int            cpu_last;
    logic [1:0]    last_grant;
    logic [1:0]    exp_q [$];

    // Reference rule: video first; otherwise the CPU port not served last.
    function automatic int model_pick(input bit [2:0] r, input int last);
        if (r[0]) return 0;
        if (r[1] && r[2]) return (last == 1) ? 2 : 1;
        if (r[1]) return 1;
        if (r[2]) return 2;
        return 3;
    endfunction

    task automatic drive_masters();
        bus.m_stb = req;
        bus.m_we  = we_a;
        for (int i = 0; i < 3; i++) begin
            bus.m_addr[i*AW +: AW] = addr_a[i];
            bus.m_din[i*DW +: DW]  = din_a[i];
        end
    endtask

    task automatic new_request(input int p);
        we_a[p]   = 1'($urandom_range(0, 1));
        addr_a[p] = AW'($urandom);
        din_a[p]  = DW'($urandom);
        req[p]    = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        req          = '0;
        bus.ram_ack  = 1'b0;
        bus.ram_dout = '0;
        drive_masters();
        @(negedge clk);
        rst_n    = 1'b1;
        cpu_last = 2;
    endtask

    // One full transaction; starts and ends on a falling edge, drops the served request.
    task automatic do_txn(input int delay, input logic [DW-1:0] dout);
        int         exp_p;
        int         lat;
        bit         seen;
        logic [2:0] oh;
        exp_p = model_pick(req, cpu_last);
        oh    = 3'b001 << exp_p;
        drive_masters();
        lat  = 0;
        seen = 1'b0;
        while (lat < 20 && !seen) begin
            @(negedge clk);
            lat++;
            if (bus.ram_stb === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || lat != 1) begin
            failures++;
            $display("FAIL stb_latency: got %0d cycles (seen=%0b), need 1", lat, seen);
        end
        last_grant = bus.grant;
        checks++;
        if (bus.grant !== 2'(exp_p)) begin
            failures++;
            $display("FAIL grant: got %0d, need %0d", bus.grant, exp_p);
        end
        checks++;
        if (bus.ram_we !== we_a[exp_p] || bus.ram_addr !== addr_a[exp_p] || bus.ram_din !== din_a[exp_p]) begin
            failures++;
            $display("FAIL ram_req: got we=%0b addr=%h din=%h, need we=%0b addr=%h din=%h",
                     bus.ram_we, bus.ram_addr, bus.ram_din, we_a[exp_p], addr_a[exp_p], din_a[exp_p]);
        end
        if (exp_p != 0) cpu_last = exp_p;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ram_stb !== 1'b1 || bus.m_ack !== 3'b000 || bus.m_err !== 3'b000 || bus.ram_addr !== addr_a[exp_p]) begin
                failures++;
                $display("FAIL busy_hold: got stb=%0b ack=%b err=%b addr=%h, need stb=1 ack=000 err=000 addr=%h",
                         bus.ram_stb, bus.m_ack, bus.m_err, bus.ram_addr, addr_a[exp_p]);
            end
        end
        bus.ram_dout = dout;
        bus.ram_ack  = 1'b1;
        #1;
        checks++;
        if (bus.m_ack !== oh || bus.m_err !== 3'b000 || bus.m_dout !== dout) begin
            failures++;
            $display("FAIL ack_steer: got ack=%b err=%b dout=%h, need ack=%b err=000 dout=%h",
                     bus.m_ack, bus.m_err, bus.m_dout, oh, dout);
        end
        @(negedge clk);
        bus.ram_ack = 1'b0;
        req[exp_p]  = 1'b0;
        drive_masters();
        checks++;
        if (bus.ram_stb !== 1'b0 || bus.grant !== GRANT_NONE) begin
            failures++;
            $display("FAIL release: got stb=%0b grant=%0d, need stb=0 grant=3", bus.ram_stb, bus.grant);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ram_stb !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_din !== '0) begin
            failures++;
            $display("FAIL reset_ram: got stb=%0b we=%0b addr=%h din=%h, need all zero",
                     bus.ram_stb, bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        checks++;
        if (bus.m_ack !== 3'b000 || bus.m_err !== 3'b000 || bus.grant !== GRANT_NONE) begin
            failures++;
            $display("FAIL reset_master: got ack=%b err=%b grant=%0d, need 000 000 3", bus.m_ack, bus.m_err, bus.grant);
        end
        checks++;
        if (dbg.state !== ARB_IDLE || dbg.wd_count !== 8'd0 || dbg.rr_last !== 2'd2) begin
            failures++;
            $display("FAIL reset_dbg: got state=%0d wd=%0d rr_last=%0d, need 0 0 2", dbg.state, dbg.wd_count, dbg.rr_last);
        end
        rst_n    = 1'b1;
        cpu_last = 2;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ram_stb !== 1'b0 || bus.grant !== GRANT_NONE) begin
            failures++;
            $display("FAIL idle_no_req: got stb=%0b grant=%0d, need 0 3", bus.ram_stb, bus.grant);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        we_a[2]   = 1'b0;
        addr_a[2] = 25'h0012345;
        din_a[2]  = DW'($urandom);
        req[2]    = 1'b1;
        do_txn(2, 32'hDEADBEEF);
        checks++;
        if (last_grant !== 2'd2) begin
            failures++;
            $display("FAIL single_read_grant: got %0d, need 2", last_grant);
        end
    endtask

    task automatic test_priority();
        logic [1:0] e;
        apply_reset();
        new_request(0); new_request(1); new_request(2);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        for (int i = 0; i < 3; i++) begin
            do_txn($urandom_range(0, 3), DW'($urandom));
            e = exp_q.pop_front();
            checks++;
            if (last_grant !== e) begin
                failures++;
                $display("FAIL prio_order[%0d]: got %0d, need %0d", i, last_grant, e);
            end
        end
        new_request(0); new_request(1); new_request(2);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        for (int i = 0; i < 6; i++) begin
            do_txn($urandom_range(0, 3), DW'($urandom));
            e = exp_q.pop_front();
            checks++;
            if (last_grant !== e) begin
                failures++;
                $display("FAIL video_rereq[%0d]: got %0d, need %0d", i, last_grant, e);
            end
            if (e != 2'd0) begin
                new_request(int'(e));
                new_request(0);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        apply_reset();
        new_request(1); new_request(2);
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 2'd1 : 2'd2);
        for (int i = 0; i < 6; i++) begin
            do_txn($urandom_range(0, 3), DW'($urandom));
            e = exp_q.pop_front();
            checks++;
            if (last_grant !== e) begin
                failures++;
                $display("FAIL rr_order[%0d]: got %0d, need %0d", i, last_grant, e);
            end
            new_request(int'(e));
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        new_request(1);
        drive_masters();
        @(negedge clk);
        checks++;
        if (bus.ram_stb !== 1'b1 || bus.grant !== 2'd1) begin
            failures++;
            $display("FAIL to_start: got stb=%0b grant=%0d, need 1 1", bus.ram_stb, bus.grant);
        end
        cpu_last = 1;
        for (int k = 1; k < TO; k++) begin
            checks++;
            if (bus.m_err !== 3'b000 || bus.m_ack !== 3'b000 || bus.ram_stb !== 1'b1) begin
                failures++;
                $display("FAIL to_early[%0d]: got err=%b ack=%b stb=%0b, need 000 000 1", k, bus.m_err, bus.m_ack, bus.ram_stb);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.m_err !== 3'b010 || bus.m_ack !== 3'b000) begin
            failures++;
            $display("FAIL to_err: got err=%b ack=%b, need 010 000", bus.m_err, bus.m_ack);
        end
        @(negedge clk);
        req[1] = 1'b0;
        drive_masters();
        checks++;
        if (bus.ram_stb !== 1'b0 || bus.grant !== GRANT_NONE || bus.m_err !== 3'b000) begin
            failures++;
            $display("FAIL to_release: got stb=%0b grant=%0d err=%b, need 0 3 000", bus.ram_stb, bus.grant, bus.m_err);
        end
        @(negedge clk);
        bus.ram_ack = 1'b1;
        #1;
        checks++;
        if (bus.m_ack !== 3'b000 || bus.m_err !== 3'b000) begin
            failures++;
            $display("FAIL stray_ack: got ack=%b err=%b, need 000 000", bus.m_ack, bus.m_err);
        end
        @(negedge clk);
        bus.ram_ack = 1'b0;
        new_request(2);
        do_txn(1, DW'($urandom));
        checks++;
        if (last_grant !== 2'd2) begin
            failures++;
            $display("FAIL after_to_grant: got %0d, need 2", last_grant);
        end
    endtask

    task automatic test_ack_at_expiry();
        logic [DW-1:0] d;
        apply_reset();
        new_request(2);
        drive_masters();
        @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        d            = DW'($urandom);
        bus.ram_dout = d;
        bus.ram_ack  = 1'b1;
        #1;
        checks++;
        if (bus.m_ack !== 3'b100 || bus.m_err !== 3'b000 || bus.m_dout !== d) begin
            failures++;
            $display("FAIL ack_vs_expiry: got ack=%b err=%b dout=%h, need 100 000 %h", bus.m_ack, bus.m_err, bus.m_dout, d);
        end
        @(negedge clk);
        bus.ram_ack = 1'b0;
        req         = '0;
        drive_masters();
        checks++;
        if (bus.ram_stb !== 1'b0 || bus.grant !== GRANT_NONE) begin
            failures++;
            $display("FAIL expiry_release: got stb=%0b grant=%0d, need 0 3", bus.ram_stb, bus.grant);
        end
    endtask

    task automatic test_reset_busy();
        apply_reset();
        new_request(2);
        drive_masters();
        repeat (3) @(negedge clk);
        req       = 3'b010;
        we_a[1]   = 1'b1;
        addr_a[1] = 25'h0000010;
        din_a[1]  = 32'hA5A5A5A5;
        drive_masters();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ram_stb !== 1'b0 || bus.grant !== GRANT_NONE || bus.ram_addr !== '0 || dbg.state !== ARB_IDLE) begin
            failures++;
            $display("FAIL reset_busy: got stb=%0b grant=%0d addr=%h state=%0d, need 0 3 0 0",
                     bus.ram_stb, bus.grant, bus.ram_addr, dbg.state);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        cpu_last = 2;
        do_txn(1, DW'($urandom));
        checks++;
        if (last_grant !== 2'd1) begin
            failures++;
            $display("FAIL post_reset_grant: got %0d, need 1", last_grant);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 3; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0) new_request(p);
            end
            if (req == 3'b000) new_request($urandom_range(0, 2));
            do_txn($urandom_range(0, 4), DW'($urandom));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        req          = '0;
        we_a         = '0;
        cpu_last     = 2;
        last_grant   = GRANT_NONE;
        bus.ram_ack  = 1'b0;
        bus.ram_dout = '0;
        for (int i = 0; i < 3; i++) begin
            addr_a[i] = '0;
            din_a[i]  = '0;
        end
        drive_masters();
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_timeout();
        test_ack_at_expiry();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
